regfile_wb_arbiter: RTL and testbench

- Write-back arbiter and scoreboard in front of the integer register bank's single write port.
- Shares that port between N_REQ write-back sources (ALU, load unit, mul/div) with round-robin arbitration.
- Registers the winning write toward the bank.
- Tracks which architectural registers have an outstanding producer, so decode can detect RAW hazards.

---
 rtl/riscv_defines.sv | 11 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_defines : register-bank geometry shared with the bank      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package riscv_defines;
   localparam int ADDR_WIDTH = 5;
   localparam int WORD_WIDTH = 32;
   localparam int N_OF_REGS  = 2**ADDR_WIDTH;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant, pointer moves past winner |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_i,
   input  logic                 advance_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] ptr_o
);
   localparam int PW = $clog2(N);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_gidx;
   logic [PW-1:0] w_idx;

   // Scan from the farthest slot back towards the pointer so the nearest valid wins.
   always_comb begin
      grant_o = '0;
      w_gidx  = '0;
      w_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = PW'((int'(r_ptr) + k) % N);
         if (req_i[w_idx]) begin
            grant_o        = '0;
            grant_o[w_idx] = 1'b1;
            w_gidx         = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= '0;
      else if (advance_i)
         r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
   end

   assign ptr_o = r_ptr;
endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_wb_arbiter : write-back arbiter + RAW scoreboard in front |
// | of the register bank write port. Option: REGFILE_WB_BYPASS_EN.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module regfile_wb_arbiter #(
   parameter int N_REQ      = 3,
   parameter int ADDR_WIDTH = riscv_defines::ADDR_WIDTH,
   parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
   parameter int N_OF_REGS  = riscv_defines::N_OF_REGS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [N_REQ*WORD_WIDTH-1:0] req_data_i,
   output logic [N_REQ-1:0]            req_ready_o,
   input  logic                        issue_valid_i,
   input  logic [ADDR_WIDTH-1:0]       issue_addr_i,
`ifdef REGFILE_WB_BYPASS_EN
   input  logic [ADDR_WIDTH-1:0]       rd_addr1_i,
   input  logic [ADDR_WIDTH-1:0]       rd_addr2_i,
   input  logic [WORD_WIDTH-1:0]       rf_data1_i,
   input  logic [WORD_WIDTH-1:0]       rf_data2_i,
   output logic [WORD_WIDTH-1:0]       fwd_data1_o,
   output logic [WORD_WIDTH-1:0]       fwd_data2_o,
`endif
   output logic                        write_en_o,
   output logic [ADDR_WIDTH-1:0]       write_addr_o,
   output logic [WORD_WIDTH-1:0]       write_data_o,
   output logic [N_OF_REGS-1:0]        busy_o
);
   logic [N_REQ-1:0]         w_grant;
   logic [N_REQ-1:0]         w_ready;
   logic                     w_advance;
   logic [$clog2(N_REQ)-1:0] w_rr_ptr_unused;  // pointer kept visible for debug only
   logic [ADDR_WIDTH-1:0]    w_sel_addr;
   logic [WORD_WIDTH-1:0]    w_sel_data;
   logic [N_OF_REGS-1:0]     w_busy_nxt;
   logic                     r_write_en;
   logic [ADDR_WIDTH-1:0]    r_write_addr;
   logic [WORD_WIDTH-1:0]    r_write_data;
   logic [N_OF_REGS-1:0]     r_busy;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_valid_i),
      .advance_i (w_advance),
      .grant_o   (w_grant),
      .ptr_o     (w_rr_ptr_unused)
   );

   assign w_ready     = rst ? '0 : w_grant;
   assign w_advance   = |w_ready;
   assign req_ready_o = w_ready;

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_ready[i]) begin
            w_sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_data = req_data_i[i*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   // Address 0 is accepted to free the requester but never reaches the bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_write_en   <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
      end else if (w_advance) begin
         r_write_en   <= (w_sel_addr != '0);
         r_write_addr <= w_sel_addr;
         r_write_data <= w_sel_data;
      end else begin
         r_write_en   <= 1'b0;
      end
   end

   // Set after clear: a newly issued producer outranks the retiring one.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_write_en)
         w_busy_nxt[r_write_addr] = 1'b0;
      if (issue_valid_i && (issue_addr_i != '0))
         w_busy_nxt[issue_addr_i] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign write_en_o   = r_write_en;
   assign write_addr_o = r_write_addr;
   assign write_data_o = r_write_data;
   assign busy_o       = r_busy;

`ifdef REGFILE_WB_BYPASS_EN
   assign fwd_data1_o = (r_write_en && (rd_addr1_i != '0) && (r_write_addr == rd_addr1_i))
                        ? r_write_data : rf_data1_i;
   assign fwd_data2_o = (r_write_en && (rd_addr2_i != '0) && (r_write_addr == rd_addr2_i))
                        ? r_write_data : rf_data2_i;
`endif
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regfile_wb_arbiter : scoreboard bench for regfile_wb_arbiter   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
   localparam int N_REQ = 3;

   typedef struct packed {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] busy;
`ifdef REGFILE_WB_BYPASS_EN
   logic [4:0]  rd_addr1, rd_addr2;
   logic [31:0] rf_data1, rf_data2, fwd_data1, fwd_data2;
`endif

   exp_t        exp_q[$];
   exp_t        e;
   int          checks   = 0;
   int          failures = 0;
   int          m_ptr    = 0;
   logic        m_en     = 1'b0;
   logic [4:0]  m_addr   = '0;
   logic [31:0] m_data   = '0;
   logic [31:0] m_busy   = '0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.N_REQ(N_REQ)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid),
      .req_addr_i    (req_addr),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .issue_valid_i (issue_valid),
      .issue_addr_i  (issue_addr),
`ifdef REGFILE_WB_BYPASS_EN
      .rd_addr1_i    (rd_addr1),
      .rd_addr2_i    (rd_addr2),
      .rf_data1_i    (rf_data1),
      .rf_data2_i    (rf_data2),
      .fwd_data1_o   (fwd_data1),
      .fwd_data2_o   (fwd_data2),
`endif
      .write_en_o    (write_en),
      .write_addr_o  (write_addr),
      .write_data_o  (write_data),
      .busy_o        (busy)
   );

   function automatic logic [2:0] model_grant(input logic [2:0] v, input int p);
      for (int k = 0; k < N_REQ; k++)
         if (v[(p + k) % N_REQ]) return 3'b001 << ((p + k) % N_REQ);
      return 3'b000;
   endfunction

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      req_addr[i*5 +: 5]   = a;
      req_data[i*32 +: 32] = d;
   endtask

   // Advances the model across one rising edge, queues the expected output, then steps the DUT.
   task automatic clock_edge();
      logic [2:0]  g;
      logic [31:0] nb;
      int          gi;
      g  = rst ? 3'b000 : model_grant(req_valid, m_ptr);
      nb = m_busy;
      if (m_en) nb[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 5'd0) nb[issue_addr] = 1'b1;
      nb[0] = 1'b0;
      if (rst) begin
         exp_q.delete();
         m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; nb = '0;
      end else if (g != 3'b000) begin
         gi = 0;
         for (int i = 0; i < N_REQ; i++) if (g[i]) gi = i;
         m_addr = req_addr[gi*5 +: 5];
         m_data = req_data[gi*32 +: 32];
         m_en   = (m_addr != 5'd0);
         m_ptr  = (gi + 1) % N_REQ;
      end else begin
         m_en = 1'b0;
      end
      m_busy = nb;
      if (!rst) exp_q.push_back('{en: m_en, addr: m_addr, data: m_data});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
      issue_valid = 1'b0; issue_addr = '0;
      clock_edge(); clock_edge();
      checks++;
      if ({write_en, write_addr, write_data} !== 38'd0) begin
         failures++;
         $display("FAIL reset_out: got en=%b addr=%0d data=%h, expected all zero", write_en, write_addr, write_data);
      end
      checks++;
      if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy: got %h expected 0", busy); end
      rst = 1'b0; issue_valid = 1'b1; issue_addr = 5'd3;
      clock_edge();
      issue_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (busy !== 32'h8) begin failures++; $display("FAIL pre_reset_busy: got %h expected 00000008", busy); end
      set_req(0, 5'd5, 32'hDEADBEEF); req_valid = 3'b001; rst = 1'b1;
      #1;
      checks++;
      if (req_ready !== 3'b000) begin failures++; $display("FAIL ready_in_reset: got %b expected 000", req_ready); end
      clock_edge();
      checks++;
      if (write_en !== 1'b0 || busy !== 32'd0) begin
         failures++;
         $display("FAIL reset_midop: got en=%b busy=%h expected en=0 busy=0", write_en, busy);
      end
      checks++;
      if (dut.u_arb.r_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr: got %0d expected 0", dut.u_arb.r_ptr); end
      rst = 1'b0; req_valid = '0;
   endtask

   task automatic test_round_robin();
      logic [2:0] want;
      set_req(0, 5'd1, 32'h101); set_req(1, 5'd2, 32'h202); set_req(2, 5'd3, 32'h303);
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         want = 3'b001 << (c % 3);
         checks++;
         if (req_ready !== want) begin failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, want); end
         clock_edge();
         e = exp_q.pop_front();
         checks++;
         if ({write_en, write_addr, write_data} !== e || write_addr !== 5'(c % 3 + 1)) begin
            failures++;
            $display("FAIL rr_out[%0d]: got en=%b addr=%0d data=%h expected en=%b addr=%0d data=%h",
                     c, write_en, write_addr, write_data, e.en, e.addr, e.data);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_single();
      set_req(2, 5'd7, 32'h12345678); req_valid = 3'b100;
      #1;
      checks++;
      if (req_ready !== 3'b100) begin failures++; $display("FAIL single_grant: got %b expected 100", req_ready); end
      clock_edge();
      e = exp_q.pop_front();
      checks++;
      if ({write_en, write_addr, write_data} !== e || {write_en, write_addr, write_data} !== {1'b1, 5'd7, 32'h12345678}) begin
         failures++;
         $display("FAIL single_out: got en=%b addr=%0d data=%h expected en=1 addr=7 data=12345678", write_en, write_addr, write_data);
      end
      req_valid = '0;
      #1;
      checks++;
      if (req_ready !== 3'b000) begin failures++; $display("FAIL idle_grant: got %b expected 000", req_ready); end
      clock_edge();
      e = exp_q.pop_front();
      checks++;
      if ({write_en, write_addr, write_data} !== e || write_en !== 1'b0) begin
         failures++;
         $display("FAIL idle_out: got en=%b addr=%0d data=%h expected en=%b addr=%0d data=%h",
                  write_en, write_addr, write_data, e.en, e.addr, e.data);
      end
   endtask

   task automatic test_addr_zero();
      set_req(1, 5'd0, 32'hCAFE0000); req_valid = 3'b010;
      #1;
      checks++;
      if (req_ready !== 3'b010) begin failures++; $display("FAIL zero_grant: got %b expected 010", req_ready); end
      clock_edge();
      req_valid = '0;
      e = exp_q.pop_front();
      checks++;
      if ({write_en, write_addr, write_data} !== e || write_en !== 1'b0) begin
         failures++;
         $display("FAIL zero_out: got en=%b addr=%0d data=%h expected en=0", write_en, write_addr, write_data);
      end
      checks++;
      if (dut.u_arb.r_ptr !== 2'd2) begin failures++; $display("FAIL zero_ptr: got %0d expected 2", dut.u_arb.r_ptr); end
   endtask

   task automatic test_scoreboard();
      issue_valid = 1'b1; issue_addr = 5'd9;
      clock_edge();
      issue_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (busy !== 32'h200 || busy !== m_busy) begin failures++; $display("FAIL sb_set: got %h expected 00000200", busy); end
      set_req(0, 5'd9, 32'h99); req_valid = 3'b001;
      clock_edge();
      req_valid = '0;
      e = exp_q.pop_front();
      checks++;
      if ({write_en, write_addr, write_data} !== e || busy[9] !== 1'b1) begin
         failures++;
         $display("FAIL sb_wb: got en=%b addr=%0d busy9=%b expected en=1 addr=9 busy9=1", write_en, write_addr, busy[9]);
      end
      clock_edge();
      e = exp_q.pop_front();
      checks++;
      if (busy !== 32'd0) begin failures++; $display("FAIL sb_clear: got %h expected 0", busy); end
      req_valid = 3'b001;
      clock_edge();
      req_valid = '0;
      e = exp_q.pop_front();
      issue_valid = 1'b1; issue_addr = 5'd9;
      clock_edge();
      e = exp_q.pop_front();
      checks++;
      if (busy !== 32'h200) begin failures++; $display("FAIL sb_set_wins: got %h expected 00000200", busy); end
      issue_addr = 5'd0;
      clock_edge();
      issue_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (busy !== 32'h200 || busy !== m_busy) begin failures++; $display("FAIL sb_issue_zero: got %h expected 00000200", busy); end
   endtask

`ifdef REGFILE_WB_BYPASS_EN
   task automatic test_bypass();
      set_req(0, 5'd4, 32'hAA55); req_valid = 3'b001;
      clock_edge();
      req_valid = '0;
      e = exp_q.pop_front();
      rd_addr1 = 5'd4; rf_data1 = 32'h1; rd_addr2 = 5'd6; rf_data2 = 32'h77;
      #1;
      checks++;
      if (fwd_data1 !== 32'hAA55) begin failures++; $display("FAIL fwd1: got %h expected 0000aa55", fwd_data1); end
      checks++;
      if (fwd_data2 !== 32'h77) begin failures++; $display("FAIL fwd2: got %h expected 00000077", fwd_data2); end
      clock_edge();
      e = exp_q.pop_front();
   endtask
`endif

   initial begin
`ifdef REGFILE_WB_BYPASS_EN
      rd_addr1 = '0; rd_addr2 = '0; rf_data1 = '0; rf_data2 = '0;
`endif
      test_reset();
      test_round_robin();
      test_single();
      test_addr_zero();
      test_scoreboard();
`ifdef REGFILE_WB_BYPASS_EN
      test_bypass();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
